// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: state encoding, select width
// and the counter-width helper.
package scan_pkg;

  // Width of the slot number / decoder select pair.
  localparam int SLOT_W = 2;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Counter must hold the larger of the two reload values; never narrower
  // than one bit.
  function automatic int cnt_width(input int dwell, input int blank);
    int max_v;
    max_v = (dwell > blank) ? dwell : blank;
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with zero flags for the current and the next value.
// It stops at zero; the owner reloads it there.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         zero,
  output logic         zero_nxt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement but never below zero.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero     = (cnt_q == '0);
  assign zero_nxt = (cnt_d == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Drives the select pair of a 2-to-4 decoder through NUM_SLOTS slots, with a
// blanking gap before every slot and per-slot / per-frame alignment pulses.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 16,
  parameter int NUM_SLOTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              hold,
  output logic              sel_a,
  output logic              sel_b,
  output logic              sel_active,
  output logic              slot_start,
  output logic              frame_done,
  output logic [SLOT_W-1:0] slot_idx
);

  localparam int                CNT_W      = cnt_width(DWELL_CYC, BLANK_CYC);
  localparam bit                HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0]  BLANK_LOAD = HAS_BLANK ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                sel_active_q, sel_active_d;
  logic                slot_start_q, slot_start_d;
  logic                frame_done_q, frame_done_d;

  logic                t_load;
  logic [CNT_W-1:0]    t_load_val;
  logic                t_dec;
  logic                t_zero;
  logic                t_zero_nxt;

  logic                enter_slot;
  logic                enter_show;

  scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .dec_en   (t_dec),
    .zero     (t_zero),
    .zero_nxt (t_zero_nxt)
  );

  // Next state, slot, timer control and the registered sel_active/slot_start.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    sel_active_d = sel_active_q;
    slot_start_d = 1'b0;
    t_load       = 1'b0;
    t_load_val   = '0;
    t_dec        = 1'b0;
    enter_slot   = 1'b0;
    enter_show   = 1'b0;

    if (!en) begin
      // Disable aborts immediately, even mid-dwell, and parks the counter at 0.
      state_d      = ST_IDLE;
      slot_d       = '0;
      sel_active_d = 1'b0;
      t_load       = 1'b1;
    end else if (!hold) begin
      t_dec = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          slot_d     = '0;
          enter_slot = 1'b1;
        end
        ST_BLANK: begin
          if (t_zero) enter_show = 1'b1;
        end
        ST_SHOW: begin
          if (t_zero) begin
            slot_d     = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
            enter_slot = 1'b1;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          slot_d       = '0;
          sel_active_d = 1'b0;
        end
      endcase

      // A new slot starts with a blank gap unless blanking is disabled.
      if (enter_slot) begin
        if (HAS_BLANK) begin
          state_d      = ST_BLANK;
          sel_active_d = 1'b0;
          t_load       = 1'b1;
          t_load_val   = BLANK_LOAD;
        end else begin
          enter_show = 1'b1;
        end
      end

      if (enter_show) begin
        state_d      = ST_SHOW;
        sel_active_d = 1'b1;
        slot_start_d = 1'b1;
        t_load       = 1'b1;
        t_load_val   = DWELL_LOAD;
      end
    end
  end

  // frame_done is high during the last SHOW cycle of the last slot; it is
  // registered from the next-cycle values so it lines up with that cycle.
  always_comb begin
    frame_done_d = en && !hold && (state_d == ST_SHOW) &&
                   (slot_d == LAST_SLOT) && t_zero_nxt;
  end

  // State, slot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      sel_active_q <= 1'b0;
      slot_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      sel_active_q <= sel_active_d;
      slot_start_q <= slot_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel_a      = slot_q[1];
  assign sel_b      = slot_q[0];
  assign slot_idx   = slot_q;
  assign sel_active = sel_active_q;
  assign slot_start = slot_start_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with three parameter sets:
//   a: DWELL=4, BLANK=2, SLOTS=4   b: DWELL=3, BLANK=0, SLOTS=3
//   c: DWELL=2, BLANK=1, SLOTS=1
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en_a, hold_a, sa_a, sb_a, act_a, ss_a, fd_a;
  logic [1:0] idx_a;
  logic       en_b, hold_b, sa_b, sb_b, act_b, ss_b, fd_b;
  logic [1:0] idx_b;
  logic       en_c, hold_c, sa_c, sb_c, act_c, ss_c, fd_c;
  logic [1:0] idx_c;

  scan_sequencer #(.DWELL_CYC(4), .BLANK_CYC(2), .NUM_SLOTS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .hold(hold_a),
    .sel_a(sa_a), .sel_b(sb_a), .sel_active(act_a),
    .slot_start(ss_a), .frame_done(fd_a), .slot_idx(idx_a)
  );

  scan_sequencer #(.DWELL_CYC(3), .BLANK_CYC(0), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .hold(hold_b),
    .sel_a(sa_b), .sel_b(sb_b), .sel_active(act_b),
    .slot_start(ss_b), .frame_done(fd_b), .slot_idx(idx_b)
  );

  scan_sequencer #(.DWELL_CYC(2), .BLANK_CYC(1), .NUM_SLOTS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .hold(hold_c),
    .sel_a(sa_c), .sel_b(sb_c), .sel_active(act_c),
    .slot_start(ss_c), .frame_done(fd_c), .slot_idx(idx_c)
  );

  typedef struct {
    logic       en;
    logic       hold;
    logic       act;
    logic [1:0] slot;
    logic       ss;
    logic       fd;
  } vec_t;

  vec_t vecs[$];

  int errors = 0;
  int checks = 0;
  int row    = 0;

  logic       prev_act_a = 1'b0;
  logic [1:0] prev_idx_a = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge, sample 1 time unit later, run the always-on checks:
  // slot_idx mirrors the select pair, and dut_a never moves its select while
  // the decoded line stays driven (a move without a blank gap is a ghost).
  task automatic step();
    @(posedge clk);
    #1;
    check("idx_a_vs_sel", idx_a, {sa_a, sb_a});
    check("idx_b_vs_sel", idx_b, {sa_b, sb_b});
    check("idx_c_vs_sel", idx_c, {sa_c, sb_c});
    if (prev_act_a && act_a) check("a_no_ghost", idx_a, prev_idx_a);
    prev_act_a = act_a;
    prev_idx_a = idx_a;
  endtask

  // Drive inputs for the next edge, then compare dut_a after that edge.
  task automatic run_a(input logic en, input logic hold, input logic act,
                       input logic [1:0] slot, input logic ss, input logic fd);
    en_a   = en;
    hold_a = hold;
    step();
    row++;
    check($sformatf("a%0d sel_active", row), act_a, act);
    check($sformatf("a%0d slot", row), idx_a, slot);
    check($sformatf("a%0d slot_start", row), ss_a, ss);
    check($sformatf("a%0d frame_done", row), fd_a, fd);
  endtask

  task automatic run_n(input int n, input logic en, input logic hold, input logic act,
                       input logic [1:0] slot, input logic ss, input logic fd);
    for (int i = 0; i < n; i++) run_a(en, hold, act, slot, ss, fd);
  endtask

  task automatic add(input logic en, input logic hold, input logic act,
                     input logic [1:0] slot, input logic ss, input logic fd);
    vec_t v;
    v.en = en; v.hold = hold; v.act = act; v.slot = slot; v.ss = ss; v.fd = fd;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic act, input logic [1:0] slot);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, act, slot, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0; hold_a = 1'b0;
    en_b   = 1'b0; hold_b = 1'b0;
    en_c   = 1'b0; hold_c = 1'b0;

    // First frame of dut_a: each row is one edge with en=1.
    add(1, 0, 0, 2'd0, 0, 0);  add(1, 0, 0, 2'd0, 0, 0);   // blank slot 0
    add(1, 0, 1, 2'd0, 1, 0);  add_n(3, 1, 2'd0);          // show slot 0 (3rd edge)
    add_n(2, 0, 2'd1);                                     // blank slot 1
    add(1, 0, 1, 2'd1, 1, 0);  add_n(3, 1, 2'd1);
    add_n(2, 0, 2'd2);
    add(1, 0, 1, 2'd2, 1, 0);  add_n(3, 1, 2'd2);
    add_n(2, 0, 2'd3);
    add(1, 0, 1, 2'd3, 1, 0);  add_n(2, 1, 2'd3);
    add(1, 0, 1, 2'd3, 0, 1);                              // frame_done at edge 24
    add_n(2, 0, 2'd0);                                     // wrap, no extra cycles
    add(1, 0, 1, 2'd0, 1, 0);                              // edge 27

    // Reset values, asserted without any clock edge mattering.
    #12;
    check("rst sel_active_a", act_a, 0);  check("rst idx_a", idx_a, 0);
    check("rst ss_a", ss_a, 0);           check("rst fd_a", fd_a, 0);
    check("rst act_b", act_b, 0);         check("rst ss_b", ss_b, 0);
    check("rst act_c", act_c, 0);         check("rst idx_c", idx_c, 0);

    @(negedge clk);
    rst_n = 1'b1;
    run_n(2, 0, 0, 0, 2'd0, 0, 0);                         // idle without en

    foreach (vecs[i]) run_a(vecs[i].en, vecs[i].hold, vecs[i].act,
                            vecs[i].slot, vecs[i].ss, vecs[i].fd);

    // Reach slot 1, counter 2, then hold for 5 edges.
    run_n(3, 1, 0, 1, 2'd0, 0, 0);
    run_n(2, 1, 0, 0, 2'd1, 0, 0);
    run_a(1, 0, 1, 2'd1, 1, 0);                            // counter 3
    run_a(1, 0, 1, 2'd1, 0, 0);                            // counter 2
    run_n(5, 1, 1, 1, 2'd1, 0, 0);                         // frozen, no pulses
    // Held cycle was counter 2; counters 1 and 0 remain, then blank slot 2.
    run_n(2, 1, 0, 1, 2'd1, 0, 0);
    run_n(2, 1, 0, 0, 2'd2, 0, 0);
    run_a(1, 0, 1, 2'd2, 1, 0);
    run_n(3, 1, 0, 1, 2'd2, 0, 0);
    run_n(2, 1, 0, 0, 2'd3, 0, 0);
    run_a(1, 0, 1, 2'd3, 1, 0);                            // counter 3
    run_n(2, 1, 0, 1, 2'd3, 0, 0);                         // counters 2, 1
    // en low on the edge that would open the frame_done cycle.
    run_a(0, 0, 0, 2'd0, 0, 0);
    run_a(0, 0, 0, 2'd0, 0, 0);
    // Restart from slot 0 with the full blank.
    run_n(2, 1, 0, 0, 2'd0, 0, 0);
    run_a(1, 0, 1, 2'd0, 1, 0);

    // Run to slot 2 mid-SHOW, then reset between edges.
    run_n(3, 1, 0, 1, 2'd0, 0, 0);
    run_n(2, 1, 0, 0, 2'd1, 0, 0);
    run_a(1, 0, 1, 2'd1, 1, 0);
    run_n(3, 1, 0, 1, 2'd1, 0, 0);
    run_n(2, 1, 0, 0, 2'd2, 0, 0);
    run_a(1, 0, 1, 2'd2, 1, 0);
    run_a(1, 0, 1, 2'd2, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst sel_active", act_a, 0);
    check("async rst sel_a", sa_a, 0);
    check("async rst sel_b", sb_a, 0);
    check("async rst slot_start", ss_a, 0);
    check("async rst frame_done", fd_a, 0);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_act_a = 1'b0;
    run_n(3, 0, 0, 0, 2'd0, 0, 0);                         // idle until en
    run_n(2, 1, 0, 0, 2'd0, 0, 0);
    run_a(1, 0, 1, 2'd0, 1, 0);                            // 3 edges after en
    en_a = 1'b0;

    // dut_b (no blanking) and dut_c (single slot) from idle, edge k = 0..
    en_b = 1'b1;
    en_c = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      check($sformatf("b%0d sel_active", k), act_b, 1);
      check($sformatf("b%0d slot", k), idx_b, (k / 3) % 3);
      check($sformatf("b%0d slot_start", k), ss_b, (k % 3) == 0);
      check($sformatf("b%0d frame_done", k), fd_b, (k % 9) == 8);
      check($sformatf("c%0d sel_active", k), act_c, (k % 3) != 0);
      check($sformatf("c%0d slot", k), idx_c, 0);
      check($sformatf("c%0d slot_start", k), ss_c, (k % 3) == 1);
      check($sformatf("c%0d frame_done", k), fd_c, (k % 3) == 2);
    end
    en_b = 1'b0;
    en_c = 1'b0;
    step();
    check("b off sel_active", act_b, 0);
    check("b off slot", idx_b, 0);
    check("c off sel_active", act_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
